// File: rtl/mips_alu_pkg.sv
// Operation codes shared by the execute-stage ALU and the instruction decoder.
package mips_alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [5:0] {
        ALU_SLL   = 6'h00,
        ALU_SRL   = 6'h02,
        ALU_SRA   = 6'h03,
        ALU_SLLV  = 6'h04,
        ALU_SRLV  = 6'h06,
        ALU_SRAV  = 6'h07,
        ALU_PASSA = 6'h08,
        ALU_LUI   = 6'h0F,
        ALU_MFHI  = 6'h10,
        ALU_MTHI  = 6'h11,
        ALU_MFLO  = 6'h12,
        ALU_MTLO  = 6'h13,
        ALU_MULT  = 6'h18,
        ALU_MULTU = 6'h19,
        ALU_DIV   = 6'h1A,
        ALU_DIVU  = 6'h1B,
        ALU_ADD   = 6'h20,
        ALU_ADDU  = 6'h21,
        ALU_SUB   = 6'h22,
        ALU_SUBU  = 6'h23,
        ALU_AND   = 6'h24,
        ALU_OR    = 6'h25,
        ALU_XOR   = 6'h26,
        ALU_NOR   = 6'h27,
        ALU_SLT   = 6'h2A,
        ALU_SLTU  = 6'h2B,
        ALU_BEQ   = 6'h30,
        ALU_BNE   = 6'h31,
        ALU_BLEZ  = 6'h32,
        ALU_BGTZ  = 6'h33,
        ALU_BLTZ  = 6'h34,
        ALU_BGEZ  = 6'h35
    } alu_op_e;

endpackage

// File: rtl/mips_alu_hilo.sv
// HI/LO architectural registers with the multiply and divide datapath.
module mips_alu_hilo
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0]   hi_reg, lo_reg, hi_next, lo_next;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   dividend, divisor, quot, rem, quot_s, rem_s;
    logic               is_signed_div;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // One unsigned divider serves both DIV and DIVU; signed divide works on
    // magnitudes and fixes signs afterwards, which also makes MIN/-1 wrap cleanly.
    assign is_signed_div = (op == ALU_DIV);
    assign dividend = (is_signed_div && a[WIDTH-1]) ? -a : a;
    assign divisor  = (is_signed_div && b[WIDTH-1]) ? -b : b;
    assign quot     = (divisor == '0) ? '0 : dividend / divisor;
    assign rem      = (divisor == '0) ? '0 : dividend % divisor;
    assign quot_s   = (is_signed_div && (a[WIDTH-1] ^ b[WIDTH-1])) ? -quot : quot;
    assign rem_s    = (is_signed_div && a[WIDTH-1]) ? -rem : rem;

    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        case (op)
            ALU_MTHI:  hi_next = a;
            ALU_MTLO:  lo_next = a;
            ALU_MULT:  {hi_next, lo_next} = prod_s;
            ALU_MULTU: {hi_next, lo_next} = prod_u;
            ALU_DIV, ALU_DIVU: begin
                if (b != '0) begin
                    hi_next = rem_s;
                    lo_next = quot_s;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule

// File: rtl/mips_alu_core.sv
// Execute-stage ALU: combinational result and branch flag, HI/LO held in mips_alu_hilo.
module mips_alu_core
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] alu_src_1,
    input  logic [WIDTH-1:0] alu_src_2,
    output logic [WIDTH-1:0] alu_result,
    output logic             branch
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi, lo;
    logic [SHW-1:0]   shamt;
    logic             a_zero;

    mips_alu_hilo #(.WIDTH(WIDTH)) u_hilo (
        .clk (clk),
        .rst (rst),
        .op  (ALUControl),
        .a   (alu_src_1),
        .b   (alu_src_2),
        .hi  (hi),
        .lo  (lo)
    );

    // Immediate and variable shifts share a path: the shamt is muxed into A upstream.
    assign shamt  = alu_src_1[SHW-1:0];
    assign a_zero = (alu_src_1 == '0);

    always_comb begin
        alu_result = '0;
        branch     = 1'b0;
        case (ALUControl)
            ALU_SLL, ALU_SLLV: alu_result = alu_src_2 << shamt;
            ALU_SRL, ALU_SRLV: alu_result = alu_src_2 >> shamt;
            ALU_SRA, ALU_SRAV: alu_result = $signed(alu_src_2) >>> shamt;
            ALU_PASSA:         alu_result = alu_src_1;
            ALU_LUI:           alu_result = {alu_src_2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_MFHI:          alu_result = hi;
            ALU_MFLO:          alu_result = lo;
            ALU_ADD, ALU_ADDU: alu_result = alu_src_1 + alu_src_2;
            ALU_SUB, ALU_SUBU: alu_result = alu_src_1 - alu_src_2;
            ALU_AND:           alu_result = alu_src_1 & alu_src_2;
            ALU_OR:            alu_result = alu_src_1 | alu_src_2;
            ALU_XOR:           alu_result = alu_src_1 ^ alu_src_2;
            ALU_NOR:           alu_result = ~(alu_src_1 | alu_src_2);
            ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(alu_src_1) < $signed(alu_src_2))};
            ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (alu_src_1 < alu_src_2)};
            ALU_BEQ:  branch = (alu_src_1 == alu_src_2);
            ALU_BNE:  branch = (alu_src_1 != alu_src_2);
            ALU_BLEZ: branch = alu_src_1[WIDTH-1] | a_zero;
            ALU_BGTZ: branch = ~alu_src_1[WIDTH-1] & ~a_zero;
            ALU_BLTZ: branch = alu_src_1[WIDTH-1];
            ALU_BGEZ: branch = ~alu_src_1[WIDTH-1];
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_alu_core.sv
// Randomized and directed checks of mips_alu_core against an arithmetic reference model.
module tb_mips_alu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ctrl;
    logic [31:0] src1, src2;
    logic [31:0] result;
    logic        br;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    always #5 clk = ~clk;

    mips_alu_core #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUControl (ctrl),
        .alu_src_1  (src1),
        .alu_src_2  (src2),
        .alu_result (result),
        .branch     (br)
    );

    function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        longint      sb;
        sh = a % 32;
        case (op)
            6'h00, 6'h04: return b << sh;
            6'h02, 6'h06: return b >> sh;
            6'h03, 6'h07: begin sb = int'(b); sb = sb >>> sh; return 32'(sb); end
            6'h08: return a;
            6'h0F: return b << 16;
            6'h10: return m_hi;
            6'h12: return m_lo;
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'h2B: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_branch(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            6'h30: return a == b;
            6'h31: return a != b;
            6'h32: return int'(a) <= 0;
            6'h33: return int'(a) > 0;
            6'h34: return int'(a) < 0;
            6'h35: return int'(a) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_write(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      p, q, r;
        logic [63:0] pu;
        case (op)
            6'h11: m_hi = a;
            6'h13: m_lo = a;
            6'h18: begin
                p = longint'(int'(a)) * longint'(int'(b));
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            6'h19: begin
                pu = 64'(a) * 64'(b);
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            6'h1A: if (b != 0) begin
                q = longint'(int'(a)) / longint'(int'(b));
                r = longint'(int'(a)) % longint'(int'(b));
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            6'h1B: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            default: ;
        endcase
    endtask

    function automatic bit is_write_op(input logic [5:0] op);
        return op == 6'h11 || op == 6'h13 || (op >= 6'h18 && op <= 6'h1B);
    endfunction

    task automatic test_reset();
        rst  = 1'b0;
        ctrl = 6'h10; src1 = 32'h0; src2 = 32'h0;
        #2;
        vectors++;
        if (result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_hi: got %08h expected %08h", result, 32'h0);
        end
        ctrl = 6'h12;
        #1;
        vectors++;
        if (result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_lo: got %08h expected %08h", result, 32'h0);
        end
        $display("reset: hi/lo read back %08h", result);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed_comb();
        logic [5:0]  ops [15] = '{6'h21, 6'h23, 6'h2A, 6'h2B, 6'h03, 6'h04, 6'h0F, 6'h30,
                                  6'h35, 6'h33, 6'h34, 6'h21, 6'h00, 6'h27, 6'h32};
        logic [31:0] as  [15] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h4, 32'h24,
                                  32'h0, 32'h5, 32'h0, 32'h0, 32'h80000000, 32'h5, 32'h0, 32'h0, 32'h0};
        logic [31:0] bs  [15] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h80000000, 32'h1, 32'h00001234,
                                  32'h5, 32'h7, 32'h7, 32'h0, 32'h5, 32'h12345678, 32'h0, 32'h9};
        logic [31:0] er  [15] = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hF8000000, 32'h10, 32'h12340000,
                                  32'h0, 32'h0, 32'h0, 32'h0, 32'hA, 32'h12345678, 32'hFFFFFFFF, 32'h0};
        logic        eb  [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            ctrl = ops[i]; src1 = as[i]; src2 = bs[i];
            #2;
            $display("directed op=%02h a=%08h b=%08h res=%08h br=%0b", ctrl, src1, src2, result, br);
            vectors++;
            if (result !== er[i]) begin
                miscompares++;
                $display("FAIL directed_result[%0d]: got %08h expected %08h", i, result, er[i]);
            end
            vectors++;
            if (br !== eb[i]) begin
                miscompares++;
                $display("FAIL directed_branch[%0d]: got %0b expected %0b", i, br, eb[i]);
            end
        end
    endtask

    task automatic test_comb_random();
        logic [31:0] exp_r;
        logic        exp_b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ctrl = 6'($urandom_range(0, 63));
            if (is_write_op(ctrl)) ctrl = 6'h3F;
            src1 = $urandom;
            src2 = $urandom;
            case ($urandom_range(0, 7))
                0: src2 = src1;
                1: src1 = 32'h0;
                2: src1 = 32'h80000000;
                default: ;
            endcase
            exp_r = ref_result(ctrl, src1, src2);
            exp_b = ref_branch(ctrl, src1, src2);
            #2;
            $display("random op=%02h a=%08h b=%08h res=%08h br=%0b", ctrl, src1, src2, result, br);
            vectors++;
            if (result !== exp_r) begin
                miscompares++;
                $display("FAIL random_result op=%02h: got %08h expected %08h", ctrl, result, exp_r);
            end
            vectors++;
            if (br !== exp_b) begin
                miscompares++;
                $display("FAIL random_branch op=%02h: got %0b expected %0b", ctrl, br, exp_b);
            end
        end
    endtask

    task automatic test_hilo_directed();
        logic [5:0]  ops [7] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1A, 6'h11, 6'h13};
        logic [31:0] as  [7] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'h7, 32'h80000000, 32'h12345678, 32'h9};
        logic [31:0] bs  [7] = '{32'h3, 32'h3, 32'h2, 32'h0, 32'hFFFFFFFF, 32'h55, 32'h66};
        logic [31:0] eh  [7] = '{32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h12345678, 32'h12345678};
        logic [31:0] el  [7] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'h9};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ctrl = ops[i]; src1 = as[i]; src2 = bs[i];
            @(posedge clk);
            model_write(ops[i], as[i], bs[i]);
            @(negedge clk);
            ctrl = 6'h10;
            #1;
            $display("hilo op=%02h a=%08h b=%08h hi=%08h", ops[i], as[i], bs[i], result);
            vectors++;
            if (result !== eh[i]) begin
                miscompares++;
                $display("FAIL hilo_hi[%0d]: got %08h expected %08h", i, result, eh[i]);
            end
            ctrl = 6'h12;
            #1;
            vectors++;
            if (result !== el[i]) begin
                miscompares++;
                $display("FAIL hilo_lo[%0d]: got %08h expected %08h", i, result, el[i]);
            end
        end
    endtask

    task automatic test_hilo_random();
        logic [5:0] wops [6] = '{6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ctrl = wops[$urandom_range(0, 5)];
            src1 = $urandom;
            src2 = $urandom;
            case ($urandom_range(0, 7))
                0: src2 = 32'h0;
                1: begin src1 = 32'h80000000; src2 = 32'hFFFFFFFF; end
                2: src2 = 32'($urandom_range(1, 9));
                default: ;
            endcase
            @(posedge clk);
            model_write(ctrl, src1, src2);
            @(negedge clk);
            $display("hilo_rand op=%02h a=%08h b=%08h", ctrl, src1, src2);
            ctrl = 6'h10;
            #1;
            vectors++;
            if (result !== m_hi) begin
                miscompares++;
                $display("FAIL hilo_rand_hi: got %08h expected %08h", result, m_hi);
            end
            ctrl = 6'h12;
            #1;
            vectors++;
            if (result !== m_lo) begin
                miscompares++;
                $display("FAIL hilo_rand_lo: got %08h expected %08h", result, m_lo);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Held MULT must be idempotent and show a zero result while selected.
        @(negedge clk);
        ctrl = 6'h18; src1 = 32'h00012345; src2 = 32'hFFFF0001;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            model_write(ctrl, src1, src2);
            #2;
            vectors++;
            if (result !== 32'h0) begin
                miscompares++;
                $display("FAIL b2b_mult_result: got %08h expected %08h", result, 32'h0);
            end
        end
        // MTHI immediately followed by MTLO on the next edge.
        @(negedge clk);
        ctrl = 6'h11; src1 = 32'hCAFEF00D;
        @(posedge clk);
        model_write(ctrl, src1, src2);
        @(negedge clk);
        ctrl = 6'h13; src1 = 32'h0BADC0DE;
        @(posedge clk);
        model_write(ctrl, src1, src2);
        @(negedge clk);
        ctrl = 6'h10;
        #1;
        $display("b2b hi=%08h", result);
        vectors++;
        if (result !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL b2b_hi: got %08h expected %08h", result, 32'hCAFEF00D);
        end
        ctrl = 6'h12;
        #1;
        vectors++;
        if (result !== 32'h0BADC0DE) begin
            miscompares++;
            $display("FAIL b2b_lo: got %08h expected %08h", result, 32'h0BADC0DE);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        ctrl = 6'h11; src1 = 32'hDEADBEEF; src2 = 32'h0;
        @(posedge clk);
        model_write(ctrl, src1, src2);
        #1;
        ctrl = 6'h10;
        #1;
        vectors++;
        if (result !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL async_pre_hi: got %08h expected %08h", result, 32'hDEADBEEF);
        end
        rst = 1'b0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        #1;
        $display("async_reset hi=%08h", result);
        vectors++;
        if (result !== 32'h0) begin
            miscompares++;
            $display("FAIL async_hi: got %08h expected %08h", result, 32'h0);
        end
        // A write held across an edge during reset must not land.
        ctrl = 6'h13; src1 = 32'h5;
        @(posedge clk);
        #1;
        ctrl = 6'h12;
        #1;
        vectors++;
        if (result !== 32'h0) begin
            miscompares++;
            $display("FAIL async_lo_blocked: got %08h expected %08h", result, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed_comb();
        test_comb_random();
        test_hilo_directed();
        test_hilo_random();
        test_back_to_back();
        test_async_reset();
        test_comb_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_alu_core.md
Name: mips_alu_core

Overview:
- Execute-stage arithmetic unit of the multicycle MIPS-I bus CPU.
- Combinationally computes the 32-bit result for R-type, immediate, shift and LUI operations, and the branch-taken flag for conditional branches.
- Holds the architectural HI/LO registers, written on the clock edge by multiply, divide, MTHI and MTLO.
- Operand muxing (rs/shamt/memory vs. rt/immediate) is done outside the block.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  system clock; HI/LO update on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears HI/LO.
- ALUControl  input  6  operation select; encoding under Behaviour.
- alu_src_1  input  32  operand A: rs value, or zero-extended shamt for immediate shifts.
- alu_src_2  input  32  operand B: rt value or extended immediate.
- alu_result  output  32  combinational result.
- branch  output  1  combinational branch-condition-true flag.

Behaviour:
- Encoding (hex). Funct-aligned codes:
  - 00 SLL, 02 SRL, 03 SRA, 04 SLLV, 06 SRLV, 07 SRAV
  - 10 MFHI, 11 MTHI, 12 MFLO, 13 MTLO
  - 18 MULT, 19 MULTU, 1A DIV, 1B DIVU
  - 20 ADD, 21 ADDU, 22 SUB, 23 SUBU
  - 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU
- Encoding, extra codes: 08 PASSA (result = A), 0F LUI, 30 BEQ, 31 BNE, 32 BLEZ, 33 BGTZ, 34 BLTZ, 35 BGEZ.
- ADD/ADDU and SUB/SUBU: A+B and A-B, modulo 2^32. ADD/SUB raise no overflow trap and behave identically to ADDU/SUBU.
- Logic ops are bitwise. NOR = ~(A|B).
- SLT: 1 if A<B signed, else 0. SLTU: same, unsigned. Result is zero-extended to 32 bits.
- Shifts: the value shifted is B, the shift amount is A[4:0]; A[31:5] is ignored. SRA/SRAV replicate B[31]. Shift by 0 returns B.
- LUI: result = {B[15:0], 16'h0}.
- MFHI/MFLO: result = current HI/LO register.
- MTHI, MTLO, MULT*, DIV*, branch codes and unknown codes drive alu_result = 0.
- Branch flag, valid only for codes 30-35; all other codes give branch = 0:
  - BEQ: A==B. BNE: A!=B.
  - BLEZ: A signed <=0. BGTZ: A signed >0. BLTZ: A[31]. BGEZ: !A[31].
  - B is ignored for BLEZ/BGTZ/BLTZ/BGEZ.
- HI/LO write on rising clk while the code is selected:
  - MULT: {HI,LO} = signed 64-bit A*B. MULTU: unsigned product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - MTHI: HI = A; LO unchanged. MTLO: LO = A; HI unchanged.
- Repeated writes: the write repeats every cycle the code is held. With stable operands this is idempotent and is legal.
- Divide by zero (B==0): HI and LO are left unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Reset: rst low clears HI = LO = 0 immediately, without waiting for clk, and overrides any write in progress. alu_result and branch stay purely combinational.
- Latency: results are combinational in the same cycle. HI/LO values are visible via MFHI/MFLO from the cycle after the write edge.
- No X propagation: every code drives defined outputs.

Decomposition:
- Shared package mips_alu_pkg holds the 6-bit ALUControl code constants, also consumed by the decoder.
- One natural sub-module, mips_alu_hilo: holds the HI/LO registers with the multiply/divide datapath and exposes hi/lo to the parent.
- Everything else is a single combinational case statement in mips_alu_core.

Test Plan:
- ADDU A=0xFFFFFFFF, B=1 -> result 0.
- SUBU A=0, B=1 -> result 0xFFFFFFFF.
- SLT A=0xFFFFFFFF, B=1 -> 1; SLTU with the same operands -> 0.
- SRA A=4, B=0x80000000 -> 0xF8000000.
- SLLV A=0x24, B=1 -> 0x10 (only A[4:0]=4 used).
- LUI B=0x00001234 -> 0x12340000.
- MULT A=0xFFFFFFFE (-2), B=3, one clk -> MFHI 0xFFFFFFFF, MFLO 0xFFFFFFFA.
- MULTU with the same operands -> HI 0x00000002, LO 0xFFFFFFFA.
- DIV A=-7, B=2 -> LO 0xFFFFFFFD, HI 0xFFFFFFFF.
- DIVU A=7, B=0 -> HI/LO retain their prior values.
- MTHI A=0xDEADBEEF, then assert rst low mid-cycle -> MFHI returns 0 before the next clk edge.
- BEQ A=B=5 -> branch 1. BGEZ A=0 -> 1. BGTZ A=0 -> 0. BLTZ A=0x80000000 -> 1.
- ADDU with A=B=5 -> branch 0 and alu_result 0xA.
